slave_mem: RTL and testbench
============================

Name: slave_mem

Overview:
- Responder (slave) end of the single-outstanding req/ack bus driven by the bus master.
- Accepts one command per handshake: write (cmd=1) stores wdata into a local register-file memory; read (cmd=0) returns the word on rdata.
- Asserts a one-cycle ack after a programmable wait-state count.
- Sits between the bus master and the rest of the design as the addressed storage target.

Parameters:
- DATA_W, 32, width of wdata/rdata and memory words.
- ADDR_W, 32, width of addr bus.
- DEPTH, 16, number of memory words; must be power of 2, ≥2.
- WAIT_CYCLES, 2, wait states between request capture and ack; 0 allowed.
- ERR_DATA, 32'hDEAD_BEEF, rdata value returned for out-of-range reads.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  1  master request; held high until master has seen ack.
- cmd  in  1  0 = read, 1 = write; valid while req high.
- addr  in  ADDR_W  word address; valid while req high.
- wdata  in  DATA_W  write data; valid while req high.
- ack  out  1  one-cycle completion pulse.
- rdata  out  DATA_W  read result; valid from ack cycle, held until next read ack.
- err  out  1  one-cycle pulse coincident with ack when addr ≥ DEPTH.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (rst_n).
  - Asserting rst_n=0 forces state=IDLE, ack=0, err=0, busy=0, rdata=0, wait counter=0, all memory words=0, regardless of clk.
  - Reset mid-transaction aborts it with no ack and no memory write.
- FSM states: IDLE, WAIT, RESP, RELEASE.
- IDLE:
  - On posedge with req=1, capture cmd, addr, wdata into internal registers.
  - Load wait counter with WAIT_CYCLES.
  - Go to WAIT if WAIT_CYCLES>0, else RESP.
- WAIT:
  - Decrement counter each cycle; go to RESP on the cycle the counter reaches 1.
  - Request fields are ignored after capture; changes on the inputs have no effect.
- RESP (single cycle):
  - ack=1, busy=1.
  - Write, in range: mem[addr] <= captured wdata on this edge.
  - Read, in range: rdata <= mem[addr], registered so it is visible in the ack cycle.
  - Out of range (captured addr ≥ DEPTH): no write; read returns rdata=ERR_DATA; err=1.
  - Next state RELEASE.
- RELEASE:
  - ack=0; wait for req=0, then go to IDLE.
  - Required because the master drops req only one cycle after sampling ack, so req is still high on the first RELEASE cycle.
  - The same request must never be accepted twice.
- Latency: ack rises WAIT_CYCLES+1 cycles after the edge where req is first sampled high.
- Minimum spacing between acks: WAIT_CYCLES+3 cycles.
- rdata changes only in RESP of a read; writes leave rdata unchanged.
- Address indexing uses addr[log2(DEPTH)-1:0]; the range check uses the full ADDR_W bits.
- req deasserting before ack (protocol violation): the captured transaction still completes with ack; ack is not suppressed.
- ack and err are never high outside RESP; busy=0 only in IDLE.

Test Plan:
- Reset, then write: rst_n low 3 cycles, release; req=1, cmd=1, addr=5, wdata=32'h1234_5678, WAIT_CYCLES=2 -> ack single pulse 3 cycles after req sampled, err=0, busy high through RELEASE.
- Read back: req=1, cmd=0, addr=5 -> rdata=32'h1234_5678 in ack cycle and held; a following write to addr=6 leaves rdata unchanged.
- Out of range: write addr=16 data 32'hAAAA_AAAA, then read addr=16 -> both ack with err=1, read rdata=32'hDEAD_BEEF; read addr=0 returns 0, showing memory untouched.
- Held req / no double accept: keep req=1 for 4 cycles after ack -> exactly one ack; second ack only after req low ≥1 cycle then high again.
- Zero wait: WAIT_CYCLES=0, read addr=3 after writing 32'h0000_00FF -> ack on the cycle after req sampled, rdata=32'h0000_00FF.
- Async reset mid-op: assert rst_n=0 between clk edges while in WAIT of a write addr=2 data 32'hFFFF_FFFF -> ack/busy drop immediately; later read addr=2 returns 0.

Source files
------------

// File: rtl/slave_mem.sv
// slave_mem: req/ack bus responder backed by a small register-file memory.
//   clk    in   system clock, all logic on posedge
//   rst_n  in   asynchronous active-low reset
//   req    in   master request, held until ack has been seen
//   cmd    in   0 = read, 1 = write
//   addr   in   word address (full width used for the range check)
//   wdata  in   write data
//   ack    out  one-cycle completion pulse
//   rdata  out  read result, valid from the ack cycle until the next read ack
//   err    out  one-cycle pulse with ack when the address is out of range
//   busy   out  high whenever the FSM is not idle
module slave_mem #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH = 16,
    parameter int WAIT_CYCLES = 2,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEAD_BEEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              cmd,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP, RELEASE} state_t;

    state_t            state, next;
    logic [CW-1:0]     cnt;
    logic              cmd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              cur_cmd;
    logic [ADDR_W-1:0] cur_addr;
    logic              cur_ok;
    logic              q_ok;

    // With zero wait states RESP follows IDLE directly, so the read must be
    // taken from the live inputs rather than the not-yet-loaded captures.
    assign cur_cmd  = (state == IDLE) ? cmd : cmd_q;
    assign cur_addr = (state == IDLE) ? addr : addr_q;
    assign cur_ok   = cur_addr < ADDR_W'(DEPTH);
    assign q_ok     = addr_q < ADDR_W'(DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = req ? ((WAIT_CYCLES > 0) ? WAIT : RESP) : IDLE;
            WAIT:    next = (cnt == CW'(1)) ? RESP : WAIT;
            RESP:    next = RELEASE;
            RELEASE: next = req ? RELEASE : IDLE;
            default: next = IDLE;
        endcase
    end

    always_comb begin
        ack  = state == RESP;
        err  = (state == RESP) && !q_ok;
        busy = state != IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            cmd_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata   <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (state == IDLE && req) begin
                cmd_q   <= cmd;
                addr_q  <= addr;
                wdata_q <= wdata;
                cnt     <= CW'(WAIT_CYCLES);
            end
            if (state == WAIT)
                cnt <= cnt - CW'(1);
            // Load rdata on the edge entering RESP so it is visible with ack.
            if (next == RESP && !cur_cmd)
                rdata <= cur_ok ? mem[cur_addr[AW-1:0]] : ERR_DATA;
            if (state == RESP && cmd_q && q_ok)
                mem[addr_q[AW-1:0]] <= wdata_q;
        end
    end
endmodule

// File: tb/tb_slave_mem.sv
module tb_slave_mem;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req [2];
    logic        cmd [2];
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic        ack [2];
    logic        err [2];
    logic        busy [2];
    logic [31:0] rdata [2];

    int          pass_cnt = 0;
    int          tot_cnt = 0;
    logic [31:0] mem_m [2][16];
    logic [31:0] rd_m [2];

    typedef struct {
        int          s;
        bit          c;
        logic [31:0] a;
        logic [31:0] d;
        int          hold;
        bit          e;
        logic [31:0] r;
    } vec_t;
    vec_t vecs [$];

    always #5 clk = ~clk;

    slave_mem #(.WAIT_CYCLES(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .req(req[0]), .cmd(cmd[0]), .addr(addr[0]),
        .wdata(wdata[0]), .ack(ack[0]), .rdata(rdata[0]), .err(err[0]), .busy(busy[0])
    );
    slave_mem #(.WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req(req[1]), .cmd(cmd[1]), .addr(addr[1]),
        .wdata(wdata[1]), .ack(ack[1]), .rdata(rdata[1]), .err(err[1]), .busy(busy[1])
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            rd_m[s] = '0;
            for (int i = 0; i < 16; i++)
                mem_m[s][i] = '0;
        end
    endtask

    // One master transaction: latency, err, rdata, single ack while req is held.
    task automatic txn(input int s, input bit c, input logic [31:0] a, input logic [31:0] d,
                       input int hold, input bit exp_e, input logic [31:0] exp_r);
        int w = (s == 0) ? 2 : 0;
        int n = 0;
        int extra = 0;
        @(negedge clk);
        req[s] = 1'b1; cmd[s] = c; addr[s] = a; wdata[s] = d;
        do begin
            @(negedge clk);
            n++;
            if (n == 1)
                check("busy_after_accept", 32'(busy[s]), 32'd1);
        end while (!ack[s] && n < 20);
        if (!ack[s]) begin
            check("ack_timeout", 32'(n), 32'(w + 1));
        end else begin
            check("ack_latency", 32'(n), 32'(w + 1));
            check("err", 32'(err[s]), 32'(exp_e));
            check("rdata", rdata[s], exp_r);
        end
        for (int i = 0; i <= hold; i++) begin
            @(negedge clk);
            if (ack[s]) extra++;
            if (i == 0)
                check("busy_release", 32'(busy[s]), 32'd1);
        end
        check("single_ack", 32'(extra), 32'd0);
        check("rdata_held", rdata[s], exp_r);
        req[s] = 1'b0;
        @(negedge clk);
        check("busy_idle", 32'(busy[s]), 32'd0);
        if (c && a < 16)
            mem_m[s][a[3:0]] = d;
        if (!c)
            rd_m[s] = (a < 16) ? mem_m[s][a[3:0]] : ERRD;
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            req[s] = 1'b0; cmd[s] = 1'b0; addr[s] = '0; wdata[s] = '0;
        end
        model_reset();
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check("rst_ack", 32'(ack[s]), 32'd0);
            check("rst_busy", 32'(busy[s]), 32'd0);
            check("rst_err", 32'(err[s]), 32'd0);
            check("rst_rdata", rdata[s], 32'd0);
        end
        rst_n = 1'b1;

        vecs.push_back('{0, 1'b1, 32'd5, 32'h1234_5678, 0, 1'b0, 32'h0});
        vecs.push_back('{0, 1'b0, 32'd5, 32'h0, 0, 1'b0, 32'h1234_5678});
        vecs.push_back('{0, 1'b1, 32'd6, 32'hCAFE_0006, 0, 1'b0, 32'h1234_5678});
        vecs.push_back('{0, 1'b1, 32'd16, 32'hAAAA_AAAA, 0, 1'b1, 32'h1234_5678});
        vecs.push_back('{0, 1'b0, 32'd16, 32'h0, 0, 1'b1, ERRD});
        vecs.push_back('{0, 1'b0, 32'd0, 32'h0, 0, 1'b0, 32'h0});
        vecs.push_back('{0, 1'b0, 32'd6, 32'h0, 4, 1'b0, 32'hCAFE_0006});
        vecs.push_back('{0, 1'b0, 32'd5, 32'h0, 0, 1'b0, 32'h1234_5678});
        vecs.push_back('{0, 1'b0, 32'h1000_0005, 32'h0, 0, 1'b1, ERRD});
        vecs.push_back('{1, 1'b1, 32'd3, 32'h0000_00FF, 0, 1'b0, 32'h0});
        vecs.push_back('{1, 1'b0, 32'd3, 32'h0, 2, 1'b0, 32'h0000_00FF});
        foreach (vecs[i])
            txn(vecs[i].s, vecs[i].c, vecs[i].a, vecs[i].d, vecs[i].hold, vecs[i].e, vecs[i].r);

        // Asynchronous reset while a write sits in its wait states.
        @(negedge clk);
        req[0] = 1'b1; cmd[0] = 1'b1; addr[0] = 32'd2; wdata[0] = 32'hFFFF_FFFF;
        @(negedge clk);
        check("midop_busy_before", 32'(busy[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midop_ack", 32'(ack[0]), 32'd0);
        check("midop_busy", 32'(busy[0]), 32'd0);
        check("midop_rdata", rdata[0], 32'd0);
        check("midop_rdata0", rdata[1], 32'd0);
        @(negedge clk);
        req[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        txn(0, 1'b0, 32'd2, 32'h0, 0, 1'b0, 32'h0);
        txn(0, 1'b0, 32'd5, 32'h0, 0, 1'b0, 32'h0);

        for (int k = 0; k < 40; k++) begin
            int          s = $urandom_range(0, 1);
            bit          c = 1'($urandom_range(0, 1));
            logic [31:0] a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 19));
            logic [31:0] d = $urandom;
            bit          e = a >= 16;
            logic [31:0] r = c ? rd_m[s] : (e ? ERRD : mem_m[s][a[3:0]]);
            txn(s, c, a, d, $urandom_range(0, 2), e, r);
        end

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
